// File: rtl/sru_pkg.sv
// Shared definitions for the shift/rotate unit: operation encodings,
// the sequencer state type and a legality helper for op codes.
package sru_pkg;

  localparam logic [2:0] OP_SHR  = 3'd0;
  localparam logic [2:0] OP_SHRA = 3'd1;
  localparam logic [2:0] OP_SHL  = 3'd2;
  localparam logic [2:0] OP_ROR  = 3'd3;
  localparam logic [2:0] OP_ROL  = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sru_state_e;

  // Codes 5..7 are reserved; such requests complete immediately with W=a.
  function automatic logic op_is_legal(input logic [2:0] op);
    return (op <= OP_ROL);
  endfunction

endpackage

// File: rtl/sru_step.sv
// One combinational shift/rotate step of k bit positions (0..STEP).
// Also reports the last bit moved out of the word by this step
// (bit k-1 for right-going ops, bit WIDTH-k for left-going ops).
module sru_step
  import sru_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  parameter int K_W   = $clog2(STEP) + 1
) (
  input  logic [WIDTH-1:0] w_i,
  input  logic [2:0]       op_i,
  input  logic [K_W-1:0]   k_i,
  output logic [WIDTH-1:0] w_o,
  output logic             carry_o
);

  localparam int IDX_W = $clog2(WIDTH);

  logic [2*WIDTH-1:0] dbl;
  logic [2*WIDTH-1:0] ror_full;
  logic [2*WIDTH-1:0] rol_full;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   l_idx;

  // Rotations use a doubled copy of the word so the wrapped bits fall out
  // of a plain shift; a step of k=0 leaves the word and carry untouched.
  always_comb begin
    dbl      = {w_i, w_i};
    ror_full = dbl >> k_i;
    rol_full = dbl << k_i;
    r_idx    = IDX_W'(k_i) - IDX_W'(1);
    l_idx    = IDX_W'(WIDTH - int'(k_i));
    w_o      = w_i;
    carry_o  = 1'b0;
    if (k_i != '0) begin
      case (op_i)
        OP_SHR: begin
          w_o     = w_i >> k_i;
          carry_o = w_i[r_idx];
        end
        OP_SHRA: begin
          w_o     = $signed(w_i) >>> k_i;
          carry_o = w_i[r_idx];
        end
        OP_SHL: begin
          w_o     = w_i << k_i;
          carry_o = w_i[l_idx];
        end
        OP_ROR: begin
          w_o     = ror_full[WIDTH-1:0];
          carry_o = w_i[r_idx];
        end
        OP_ROL: begin
          w_o     = rol_full[2*WIDTH-1:WIDTH];
          carry_o = w_i[l_idx];
        end
        default: begin
          w_o     = w_i;
          carry_o = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/shift_rotate_unit.sv
// Iterative shift/rotate unit: moves up to STEP bit positions per RUN
// cycle under a start/busy/done handshake.
// Optional feature: define SRU_CARRY_EN to add the 'carry' output, which
// holds the last bit shifted/rotated out and updates together with result.
//
// Handshake: start is sampled only in IDLE or DONE; a sampled start latches
// op/a/amt. busy is high exactly while RUN; done is high for the single
// cycle in DONE, and result is valid from that cycle until the next
// accepted start or reset. Holding start in DONE chains operations with
// no idle cycle. The FSM state is visible as state_q.
module shift_rotate_unit
  import sru_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     start,
  input  logic [2:0]               op,
  input  logic [WIDTH-1:0]         a,
  input  logic [$clog2(WIDTH)-1:0] amt,
  output logic                     busy,
  output logic                     done,
`ifdef SRU_CARRY_EN
  output logic [WIDTH-1:0]         result,
  output logic                     carry
`else
  output logic [WIDTH-1:0]         result
`endif
);

  localparam int AW  = $clog2(WIDTH);
  localparam int K_W = $clog2(STEP) + 1;

  sru_state_e       state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] w_q, w_d;
  logic [AW-1:0]    rem_q, rem_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [K_W-1:0]   k;
  logic [WIDTH-1:0] step_w;
  logic             step_carry;
`ifdef SRU_CARRY_EN
  logic             carry_q, carry_d;
`else
  logic             unused_step_carry;
  assign unused_step_carry = step_carry;
`endif

  // Bits to move this cycle: min(STEP, REM).
  always_comb begin
    if (rem_q >= AW'(STEP)) k = K_W'(STEP);
    else                    k = K_W'(rem_q);
  end

  sru_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .K_W   (K_W)
  ) u_step (
    .w_i     (w_q),
    .op_i    (op_q),
    .k_i     (k),
    .w_o     (step_w),
    .carry_o (step_carry)
  );

  // Next-state and datapath update; result only changes on entry to DONE.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    w_d      = w_q;
    rem_d    = rem_q;
    result_d = result_q;
`ifdef SRU_CARRY_EN
    carry_d  = carry_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          op_d  = op;
          w_d   = a;
          rem_d = amt;
          if ((amt == '0) || !op_is_legal(op)) begin
            state_d  = DONE;
            result_d = a;
`ifdef SRU_CARRY_EN
            carry_d  = 1'b0;
`endif
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        w_d   = step_w;
        rem_d = rem_q - AW'(k);
        if (rem_d == '0) begin
          state_d  = DONE;
          result_d = step_w;
`ifdef SRU_CARRY_EN
          carry_d  = step_carry;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; clr aborts any operation in progress.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q  <= IDLE;
      op_q     <= '0;
      w_q      <= '0;
      rem_q    <= '0;
      result_q <= '0;
`ifdef SRU_CARRY_EN
      carry_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      w_q      <= w_d;
      rem_q    <= rem_d;
      result_q <= result_d;
`ifdef SRU_CARRY_EN
      carry_q  <= carry_d;
`endif
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign result = result_q;
`ifdef SRU_CARRY_EN
  assign carry  = carry_q;
`endif

endmodule

// File: tb/tb_shift_rotate_unit.sv
// Bench for shift_rotate_unit: one STEP=1 and one STEP=4 instance, directed
// cases plus random operations checked against an arithmetic model.
module tb_shift_rotate_unit;
  import sru_pkg::*;

  logic        clk = 1'b0;
  logic        clr;
  logic        start1, start4;
  logic [2:0]  op;
  logic [31:0] a;
  logic [4:0]  amt;
  logic        busy1, done1, busy4, done4;
  logic [31:0] res1, res4;
`ifdef SRU_CARRY_EN
  logic        carry1, carry4;
`endif

  int total = 0;
  int bad   = 0;

  // clock
  always #5 clk = ~clk;

  shift_rotate_unit #(.WIDTH(32), .STEP(1)) dut1 (
    .clk(clk), .clr(clr), .start(start1), .op(op), .a(a), .amt(amt),
    .busy(busy1), .done(done1),
`ifdef SRU_CARRY_EN
    .result(res1), .carry(carry1)
`else
    .result(res1)
`endif
  );

  shift_rotate_unit #(.WIDTH(32), .STEP(4)) dut4 (
    .clk(clk), .clr(clr), .start(start4), .op(op), .a(a), .amt(amt),
    .busy(busy4), .done(done4),
`ifdef SRU_CARRY_EN
    .result(res4), .carry(carry4)
`else
    .result(res4)
`endif
  );

  // Reference model: whole-operation arithmetic on the original operand.
  function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] av, input int am);
    logic [63:0] d;
    d = {av, av};
    if (am == 0 || o > 3'd4) return av;
    case (o)
      OP_SHR:  return av >> am;
      OP_SHRA: return $signed(av) >>> am;
      OP_SHL:  return av << am;
      OP_ROR:  begin d = d >> am; return d[31:0]; end
      default: begin d = d << am; return d[63:32]; end
    endcase
  endfunction

  function automatic logic ref_carry(input logic [2:0] o, input logic [31:0] av, input int am);
    if (am == 0 || o > 3'd4) return 1'b0;
    if (o == OP_SHL || o == OP_ROL) return av[32-am];
    return av[am-1];
  endfunction

  function automatic int ref_lat(input logic [2:0] o, input int am, input int step);
    if (am == 0 || o > 3'd4) return 1;
    return 1 + (am + step - 1) / step;
  endfunction

  function automatic logic get_busy(input int sel);
    return (sel == 4) ? busy4 : busy1;
  endfunction
  function automatic logic get_done(input int sel);
    return (sel == 4) ? done4 : done1;
  endfunction
  function automatic logic [31:0] get_res(input int sel);
    return (sel == 4) ? res4 : res1;
  endfunction
`ifdef SRU_CARRY_EN
  function automatic logic get_carry(input int sel);
    return (sel == 4) ? carry4 : carry1;
  endfunction
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one request on the chosen instance and follow it to completion.
  task automatic run_op(input int sel, input logic [2:0] o, input logic [31:0] av,
                        input logic [4:0] am, input logic [31:0] er, input logic ec,
                        input string tag);
    int lat;
    lat = ref_lat(o, int'(am), (sel == 4) ? 4 : 1);
    @(negedge clk);
    op = o; a = av; amt = am;
    if (sel == 4) start4 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; start4 = 1'b0;
    for (int c = 1; c <= lat; c++) begin
      if (c < lat) begin
        chk({tag, "_busy"}, 32'(get_busy(sel)), 32'd1);
        chk({tag, "_early_done"}, 32'(get_done(sel)), 32'd0);
      end else begin
        chk({tag, "_done"}, 32'(get_done(sel)), 32'd1);
        chk({tag, "_busy_in_done"}, 32'(get_busy(sel)), 32'd0);
        chk({tag, "_result"}, get_res(sel), er);
`ifdef SRU_CARRY_EN
        chk({tag, "_carry"}, 32'(get_carry(sel)), 32'(ec));
`endif
      end
      @(negedge clk);
    end
    chk({tag, "_done_pulse"}, 32'(get_done(sel)), 32'd0);
    chk({tag, "_result_held"}, get_res(sel), er);
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra;
    logic [4:0]  ram;
    int          sel;

    // reset
    clr = 1'b0; start1 = 1'b0; start4 = 1'b0; op = '0; a = '0; amt = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy1", 32'(busy1), 32'd0);
    chk("rst_done1", 32'(done1), 32'd0);
    chk("rst_res1", res1, 32'd0);
    chk("rst_busy4", 32'(busy4), 32'd0);
    chk("rst_done4", 32'(done4), 32'd0);
    chk("rst_res4", res4, 32'd0);
`ifdef SRU_CARRY_EN
    chk("rst_carry1", 32'(carry1), 32'd0);
    chk("rst_carry4", 32'(carry4), 32'd0);
`endif
    clr = 1'b1;

    // directed cases
    run_op(1, OP_ROR,  32'h00000001, 5'd4,  32'h10000000, 1'b0, "ror4");
    run_op(1, OP_SHRA, 32'h80000000, 5'd4,  32'hF8000000, 1'b0, "shra4");
    run_op(1, OP_SHR,  32'h80000000, 5'd4,  32'h08000000, 1'b0, "shr4");
    run_op(1, OP_ROL,  32'h80000001, 5'd1,  32'h00000003, 1'b1, "rol1");
    run_op(1, OP_ROR,  32'hDEADBEEF, 5'd0,  32'hDEADBEEF, 1'b0, "amt0");
    run_op(1, 3'd6,    32'hDEADBEEF, 5'd5,  32'hDEADBEEF, 1'b0, "illegal6");
    run_op(4, OP_ROR,  32'h00000001, 5'd7,  32'h02000000, 1'b0, "s4_ror7");
    run_op(4, OP_SHL,  32'h00000003, 5'd31, 32'h80000000, 1'b1, "s4_shl31");
    run_op(4, OP_SHR,  32'h80000000, 5'd31, 32'h00000001, 1'b0, "s4_shr31");
    run_op(4, OP_ROR,  32'hDEADBEEF, 5'd0,  32'hDEADBEEF, 1'b0, "s4_amt0");

    // random operations against the model
    for (int i = 0; i < 40; i++) begin
      sel = (i % 2 == 0) ? 1 : 4;
      ro  = 3'($urandom_range(0, 7));
      ra  = $urandom;
      ram = 5'($urandom_range(0, 31));
      run_op(sel, ro, ra, ram, ref_res(ro, ra, int'(ram)), ref_carry(ro, ra, int'(ram)), "rand");
    end

    // start held through RUN with new operands, then accepted in DONE
    @(negedge clk);
    op = OP_ROR; a = 32'h00000001; amt = 5'd3; start1 = 1'b1;
    @(negedge clk);
    op = OP_SHL; a = 32'h00000001; amt = 5'd2;
    for (int c = 1; c < 4; c++) begin
      chk("b2b_first_busy", 32'(busy1), 32'd1);
      @(negedge clk);
    end
    chk("b2b_first_done", 32'(done1), 32'd1);
    chk("b2b_first_result", res1, ref_res(OP_ROR, 32'h00000001, 3));
    @(negedge clk);
    start1 = 1'b0;
    chk("b2b_no_idle", 32'(busy1), 32'd1);
    @(negedge clk);
    chk("b2b_second_busy", 32'(busy1), 32'd1);
    @(negedge clk);
    chk("b2b_second_done", 32'(done1), 32'd1);
    chk("b2b_second_result", res1, 32'h00000004);
    @(negedge clk);
    chk("b2b_back_idle", 32'(done1), 32'd0);

    // clr mid-RUN aborts with no done pulse
    @(negedge clk);
    op = OP_ROR; a = 32'h000000F0; amt = 5'd10; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_busy_before", 32'(busy1), 32'd1);
    clr = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy1), 32'd0);
    chk("abort_done", 32'(done1), 32'd0);
    chk("abort_result", res1, 32'd0);
    clr = 1'b1;
    for (int c = 0; c < 12; c++) begin
      chk("abort_no_done", 32'(done1), 32'd0);
      @(negedge clk);
    end
    run_op(1, OP_SHRA, 32'hC0000000, 5'd2, 32'hF0000000, 1'b0, "after_clr");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
